// File: rtl/stopwatch_pkg.sv
// Shared encodings for the stopwatch run/done handshake: FSM state values and
// the active-low seven-segment digit patterns, bit order {g,f,e,d,c,b,a}.
package stopwatch_pkg;

  typedef enum logic [1:0] {
    StIdle   = 2'b00,
    StLaunch = 2'b01,
    StWait   = 2'b10,
    StCool   = 2'b11
  } state_e;

  localparam logic [6:0] Seg0     = 7'b100_0000;
  localparam logic [6:0] Seg1     = 7'b111_1001;
  localparam logic [6:0] Seg2     = 7'b010_0100;
  localparam logic [6:0] Seg3     = 7'b011_0000;
  localparam logic [6:0] Seg4     = 7'b001_1001;
  localparam logic [6:0] Seg5     = 7'b001_0010;
  localparam logic [6:0] Seg6     = 7'b000_0010;
  localparam logic [6:0] Seg7     = 7'b111_1000;
  localparam logic [6:0] Seg8     = 7'b000_0000;
  localparam logic [6:0] Seg9     = 7'b001_0000;
  localparam logic [6:0] SegBlank = 7'h7F;

endpackage

// File: rtl/key_debouncer.sv
// Raw active-low key -> 2-FF synchronizer -> level debouncer -> one-cycle
// press pulse on the accepted 1->0 transition.
module key_debouncer #(
  parameter int unsigned DEBOUNCE_CNT = 4
) (
  input  logic clk,
  input  logic reset_n,
  input  logic i_key_n,
  output logic o_press
);

  localparam int unsigned CntW = (DEBOUNCE_CNT > 1) ? $clog2(DEBOUNCE_CNT) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(DEBOUNCE_CNT - 1);

  logic            sync1_q, sync2_q;
  logic            key_db_q, key_db_d;
  logic [CntW-1:0] db_cnt_q, db_cnt_d;
  logic            press_q, press_d;

  // Count consecutive cycles the synced level disagrees with the accepted one.
  always_comb begin
    key_db_d = key_db_q;
    db_cnt_d = '0;
    press_d  = 1'b0;
    if (sync2_q != key_db_q) begin
      if (db_cnt_q == CntMax) begin
        key_db_d = sync2_q;
        // Only the falling (press) transition generates a pulse.
        press_d  = ~sync2_q;
      end else begin
        db_cnt_d = db_cnt_q + 1'b1;
      end
    end
  end

  // Synchronizer and debounce state.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      sync1_q  <= 1'b1;
      sync2_q  <= 1'b1;
      key_db_q <= 1'b1;
      db_cnt_q <= '0;
      press_q  <= 1'b0;
    end else begin
      sync1_q  <= i_key_n;
      sync2_q  <= sync1_q;
      key_db_q <= key_db_d;
      db_cnt_q <= db_cnt_d;
      press_q  <= press_d;
    end
  end

  assign o_press = press_q;

endmodule

// File: rtl/run_launcher.sv
// Initiator side of the run/done handshake: debounced key press launches a
// single-cycle run, waits for done with a timeout, and counts completed runs
// on two seven-segment digits.
module run_launcher
  import stopwatch_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CNT = 4,
  parameter int unsigned TIMEOUT_CNT  = 64
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       i_key_n,
  input  logic       i_idle,
  input  logic       i_done,
  output logic       o_run,
  output logic       o_busy,
  output logic       o_timeout,
  output logic [6:0] o_seven0,
  output logic [6:0] o_seven1
);

  localparam int unsigned TimerW = (TIMEOUT_CNT > 1) ? $clog2(TIMEOUT_CNT) : 1;
  localparam logic [TimerW-1:0] TimerMax = TimerW'(TIMEOUT_CNT - 1);

  state_e            state_q;
  logic [TimerW-1:0] timer_q;
  logic              run_q, busy_q, timeout_q;
  logic [3:0]        ones_q, tens_q;
  logic [6:0]        seven0_q, seven1_q;
  logic              press;

  key_debouncer #(
    .DEBOUNCE_CNT (DEBOUNCE_CNT)
  ) u_key_debouncer (
    .clk     (clk),
    .reset_n (reset_n),
    .i_key_n (i_key_n),
    .o_press (press)
  );

  function automatic logic [6:0] bcd_to_seg(input logic [3:0] digit);
    logic [6:0] seg;
    case (digit)
      4'd0:    seg = Seg0;
      4'd1:    seg = Seg1;
      4'd2:    seg = Seg2;
      4'd3:    seg = Seg3;
      4'd4:    seg = Seg4;
      4'd5:    seg = Seg5;
      4'd6:    seg = Seg6;
      4'd7:    seg = Seg7;
      4'd8:    seg = Seg8;
      4'd9:    seg = Seg9;
      default: seg = SegBlank;
    endcase
    return seg;
  endfunction

  // Handshake FSM with registered run/busy/timeout and the BCD run counter.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q   <= StIdle;
      timer_q   <= '0;
      run_q     <= 1'b0;
      busy_q    <= 1'b0;
      timeout_q <= 1'b0;
      ones_q    <= 4'd0;
      tens_q    <= 4'd0;
    end else begin
      run_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          // Presses while the worker is not idle are dropped, not queued.
          if (press && i_idle) begin
            state_q   <= StLaunch;
            run_q     <= 1'b1;
            busy_q    <= 1'b1;
            timeout_q <= 1'b0;
            timer_q   <= '0;
          end
        end
        StLaunch: begin
          state_q   <= StWait;
          timeout_q <= 1'b0;
          timer_q   <= '0;
        end
        StWait: begin
          // Done takes priority over a coincident expiry.
          if (i_done) begin
            state_q <= StCool;
            if (ones_q == 4'd9) begin
              ones_q <= 4'd0;
              tens_q <= (tens_q == 4'd9) ? 4'd0 : tens_q + 4'd1;
            end else begin
              ones_q <= ones_q + 4'd1;
            end
          end else if (timer_q == TimerMax) begin
            state_q   <= StIdle;
            busy_q    <= 1'b0;
            timeout_q <= 1'b1;
          end else begin
            timer_q <= timer_q + 1'b1;
          end
        end
        StCool: begin
          // Hold until the worker drops its done level.
          if (!i_done) begin
            state_q <= StIdle;
            busy_q  <= 1'b0;
          end
        end
      endcase
    end
  end

  // Segment registers follow the count one cycle later; blank during reset.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      seven0_q <= SegBlank;
      seven1_q <= SegBlank;
    end else begin
      seven0_q <= bcd_to_seg(ones_q);
      seven1_q <= bcd_to_seg(tens_q);
    end
  end

  assign o_run     = run_q;
  assign o_busy    = busy_q;
  assign o_timeout = timeout_q;
  assign o_seven0  = seven0_q;
  assign o_seven1  = seven1_q;

endmodule
